// File: rtl/taxi_pkg.sv
// Shared definitions for the taxi meter: trip states and BCD digit limits.
// Also used by the fare and display logic.
package taxi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } taxi_state_e;

    localparam int                     BCD_DIGIT_W   = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd2_sat_cnt.sv
// Two-digit BCD up-counter {tens,ones} that sticks at 99.
// Clear takes priority over increment.
module bcd2_sat_cnt
    import taxi_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     inc_i,
    output logic [2*BCD_DIGIT_W-1:0] cnt_o
);

    logic [BCD_DIGIT_W-1:0] tens_q, tens_d;
    logic [BCD_DIGIT_W-1:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc_i && !(tens_q == BCD_MAX_DIGIT && ones_q == BCD_MAX_DIGIT)) begin
            if (ones_q == BCD_MAX_DIGIT) begin
                ones_d = '0;
                tens_d = tens_q + 1'b1;
            end else begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign cnt_o = {tens_q, ones_q};

endmodule

// File: rtl/taxi_trip_ctrl.sv
// Trip sequencer: turns key edges and the wheel sensor into distance-counter
// step/clear strobes, and tracks waiting minutes while the cab stands still.
module taxi_trip_ctrl
    import taxi_pkg::*;
#(
    parameter int PULSES_PER_UNIT = 4,
    parameter int IDLE_TIMEOUT    = 5000,
    parameter int TICKS_PER_MIN   = 60000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start,
    input  logic       key_stop,
    input  logic       key_clear,
    input  logic       wheel_in,
    output logic       dist_step,
    output logic       dist_clr_n,
    output logic [7:0] wait_min,
    output logic [1:0] state,
    output logic       meter_on
);

    localparam int PULSE_W = (PULSES_PER_UNIT > 1) ? $clog2(PULSES_PER_UNIT) : 1;
    localparam int TO_W    = $clog2(IDLE_TIMEOUT);
    localparam int TICK_W  = $clog2(TICKS_PER_MIN);

    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSES_PER_UNIT - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(IDLE_TIMEOUT - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_MIN - 1);

    taxi_state_e         state_q, state_d;
    logic [2:0]          wheelSync_q;
    logic                wheelEdge_q;
    logic                keyStart_q, keyStop_q, keyClear_q;
    logic [PULSE_W-1:0]  pulse_q, pulse_d;
    logic [TO_W-1:0]     timeout_q, timeout_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                distStep_q, distStep_d;
    logic                distClrN_q, meterOn_q;
    logic                startEdge, stopEdge, clearEdge;
    logic                countEdge, minClr, minInc;

    assign startEdge = key_start & ~keyStart_q;
    assign stopEdge  = key_stop  & ~keyStop_q;
    assign clearEdge = key_clear & ~keyClear_q;

    always_comb begin
        state_d    = state_q;
        pulse_d    = pulse_q;
        timeout_d  = timeout_q;
        tick_d     = tick_q;
        distStep_d = 1'b0;
        countEdge  = 1'b0;
        minClr     = 1'b0;
        minInc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (startEdge) begin
                    state_d   = ST_RUN;
                    pulse_d   = '0;
                    timeout_d = '0;
                    tick_d    = '0;
                    minClr    = 1'b1;
                end
            end
            ST_RUN: begin
                if (stopEdge) begin
                    state_d = ST_HOLD;
                end else begin
                    countEdge = wheelEdge_q;
                    if (wheelEdge_q) begin
                        timeout_d = '0;
                    end else if (timeout_q == TO_LAST) begin
                        state_d   = ST_WAIT;
                        timeout_d = '0;
                    end else begin
                        timeout_d = timeout_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (stopEdge) begin
                    state_d = ST_HOLD;
                    tick_d  = '0;
                end else if (wheelEdge_q) begin
                    state_d   = ST_RUN;
                    countEdge = 1'b1;
                    tick_d    = '0;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    minInc = 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (clearEdge) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A partial unit survives RUN<->WAIT; only the wrap produces a step.
        if (countEdge) begin
            if (pulse_q == PULSE_LAST) begin
                pulse_d    = '0;
                distStep_d = 1'b1;
            end else begin
                pulse_d = pulse_q + 1'b1;
            end
        end
    end

    // Key history resets high so a key held through reset does not look like a press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wheelSync_q <= '0;
            wheelEdge_q <= 1'b0;
            keyStart_q  <= 1'b1;
            keyStop_q   <= 1'b1;
            keyClear_q  <= 1'b1;
            pulse_q     <= '0;
            timeout_q   <= '0;
            tick_q      <= '0;
            distStep_q  <= 1'b0;
            distClrN_q  <= 1'b0;
            meterOn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wheelSync_q <= {wheelSync_q[1:0], wheel_in};
            wheelEdge_q <= wheelSync_q[1] & ~wheelSync_q[2];
            keyStart_q  <= key_start;
            keyStop_q   <= key_stop;
            keyClear_q  <= key_clear;
            pulse_q     <= pulse_d;
            timeout_q   <= timeout_d;
            tick_q      <= tick_d;
            distStep_q  <= distStep_d;
            distClrN_q  <= (state_d != ST_IDLE);
            meterOn_q   <= (state_d != ST_IDLE);
        end
    end

    bcd2_sat_cnt u_waitMin (
        .clk   (clk),
        .reset (reset),
        .clr_i (minClr),
        .inc_i (minInc),
        .cnt_o (wait_min)
    );

    assign dist_step  = distStep_q;
    assign dist_clr_n = distClrN_q;
    assign state      = state_q;
    assign meter_on   = meterOn_q;

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Directed bench for taxi_trip_ctrl with short timeouts (4 pulses/unit, 20-cycle
// idle timeout, 10-cycle minute); expected values are hand-derived per scenario.
module tb_taxi_trip_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       keyStart = 1'b0;
    logic       keyStop = 1'b0;
    logic       keyClear = 1'b0;
    logic       wheelIn = 1'b0;
    logic       distStep;
    logic       distClrN;
    logic [7:0] waitMin;
    logic [1:0] state;
    logic       meterOn;

    int errors = 0;
    int checks = 0;
    int stepCount = 0;

    taxi_trip_ctrl #(
        .PULSES_PER_UNIT (4),
        .IDLE_TIMEOUT    (20),
        .TICKS_PER_MIN   (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_start  (keyStart),
        .key_stop   (keyStop),
        .key_clear  (keyClear),
        .wheel_in   (wheelIn),
        .dist_step  (distStep),
        .dist_clr_n (distClrN),
        .wait_min   (waitMin),
        .state      (state),
        .meter_on   (meterOn)
    );

    always #5 clk = ~clk;

    // Steps are counted mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (distStep === 1'b1) stepCount++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wheel high for 3 cycles, low for 3; the edge is acted on 4 edges after rising.
    task automatic pulseWheel();
        wheelIn = 1'b1;
        repeat (3) tick();
        wheelIn = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pressKey(input int which);
        if (which == 0) keyStart = 1'b1;
        if (which == 1) keyStop  = 1'b1;
        if (which == 2) keyClear = 1'b1;
        tick();
        keyStart = 1'b0;
        keyStop  = 1'b0;
        keyClear = 1'b0;
    endtask

    task automatic waitForState(input logic [1:0] target, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (state === target) begin
                found = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        keyStart = 1'b1;
        repeat (3) tick();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        checks++; if (distClrN !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr_n: got %b expected 0", distClrN); end
        checks++; if (distStep !== 1'b0) begin errors++; $display("[TB] FAIL reset_step: got %b expected 0", distStep); end
        checks++; if (waitMin !== 8'h00) begin errors++; $display("[TB] FAIL reset_wait_min: got %h expected 00", waitMin); end
        checks++; if (meterOn !== 1'b0) begin errors++; $display("[TB] FAIL reset_meter_on: got %b expected 0", meterOn); end
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL held_start_state: got %0d expected 0", state); end
        checks++; if (distClrN !== 1'b0) begin errors++; $display("[TB] FAIL held_start_clr_n: got %b expected 0", distClrN); end
        keyStart = 1'b0;
        tick();
    endtask

    task automatic test_distance();
        int base;
        pressKey(0);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL start_state: got %0d expected 1", state); end
        checks++; if (distClrN !== 1'b1) begin errors++; $display("[TB] FAIL start_clr_n: got %b expected 1", distClrN); end
        checks++; if (meterOn !== 1'b1) begin errors++; $display("[TB] FAIL start_meter_on: got %b expected 1", meterOn); end
        base = stepCount;
        repeat (3) pulseWheel();
        wheelIn = 1'b1;
        repeat (3) tick();
        checks++; if (distStep !== 1'b0) begin errors++; $display("[TB] FAIL step_early: got %b expected 0", distStep); end
        wheelIn = 1'b0;
        tick();
        checks++; if (distStep !== 1'b1) begin errors++; $display("[TB] FAIL step_latency: got %b expected 1", distStep); end
        tick();
        checks++; if (distStep !== 1'b0) begin errors++; $display("[TB] FAIL step_width: got %b expected 0", distStep); end
        tick();
        repeat (4) pulseWheel();
        checks++; if (stepCount - base !== 2) begin errors++; $display("[TB] FAIL eight_pulse_steps: got %0d expected 2", stepCount - base); end
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL run_state: got %0d expected 1", state); end
    endtask

    task automatic test_wait_timeout();
        int base;
        pulseWheel();
        repeat (17) tick();
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL timeout_early: got %0d expected 1", state); end
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL timeout_wait: got %0d expected 2", state); end
        repeat (35) tick();
        checks++; if (waitMin !== 8'h03) begin errors++; $display("[TB] FAIL wait_three_min: got %h expected 03", waitMin); end
        pulseWheel();
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL resume_state: got %0d expected 1", state); end
        checks++; if (waitMin !== 8'h03) begin errors++; $display("[TB] FAIL resume_wait_min: got %h expected 03", waitMin); end
        base = stepCount;
        repeat (3) pulseWheel();
        checks++; if (stepCount - base !== 1) begin errors++; $display("[TB] FAIL partial_kept_steps: got %0d expected 1", stepCount - base); end
    endtask

    task automatic test_minute_saturation();
        bit found;
        int base;
        int v;
        logic [7:0] expMin;
        pressKey(1);
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL stop_state: got %0d expected 3", state); end
        tick();
        checks++; if (waitMin !== 8'h03) begin errors++; $display("[TB] FAIL hold_wait_min: got %h expected 03", waitMin); end
        pressKey(2);
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL clear_state: got %0d expected 0", state); end
        pressKey(0);
        checks++; if (waitMin !== 8'h00) begin errors++; $display("[TB] FAIL restart_wait_min: got %h expected 00", waitMin); end
        base = stepCount;
        repeat (3) pulseWheel();
        checks++; if (stepCount - base !== 0) begin errors++; $display("[TB] FAIL three_pulse_steps: got %0d expected 0", stepCount - base); end
        waitForState(2'd2, 40, found);
        checks++; if (!found) begin errors++; $display("[TB] FAIL enter_wait: got state %0d expected 2", state); end
        for (int n = 1; n <= 105; n++) begin
            repeat (10) tick();
            v = (n > 99) ? 99 : n;
            expMin = {4'(v / 10), 4'(v % 10)};
            checks++;
            if (waitMin !== expMin) begin
                errors++;
                $display("[TB] FAIL minute_%0d: got %h expected %h", n, waitMin, expMin);
            end
        end
    endtask

    task automatic test_hold();
        int base;
        base = stepCount;
        wheelIn = 1'b1;
        repeat (3) tick();
        keyStop = 1'b1;
        tick();
        keyStop = 1'b0;
        wheelIn = 1'b0;
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL stop_vs_wheel_state: got %0d expected 3", state); end
        repeat (4) tick();
        checks++; if (stepCount - base !== 0) begin errors++; $display("[TB] FAIL stop_vs_wheel_steps: got %0d expected 0", stepCount - base); end
        pressKey(0);
        repeat (2) pulseWheel();
        checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL hold_ignore_state: got %0d expected 3", state); end
        checks++; if (stepCount - base !== 0) begin errors++; $display("[TB] FAIL hold_ignore_steps: got %0d expected 0", stepCount - base); end
        checks++; if (waitMin !== 8'h99) begin errors++; $display("[TB] FAIL hold_frozen_min: got %h expected 99", waitMin); end
        checks++; if (meterOn !== 1'b1) begin errors++; $display("[TB] FAIL hold_meter_on: got %b expected 1", meterOn); end
        pressKey(2);
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL hold_clear_state: got %0d expected 0", state); end
        checks++; if (distClrN !== 1'b0) begin errors++; $display("[TB] FAIL hold_clear_clr_n: got %b expected 0", distClrN); end
        checks++; if (meterOn !== 1'b0) begin errors++; $display("[TB] FAIL hold_clear_meter_on: got %b expected 0", meterOn); end
        checks++; if (waitMin !== 8'h99) begin errors++; $display("[TB] FAIL idle_keeps_min: got %h expected 99", waitMin); end
    endtask

    task automatic test_mid_trip_reset();
        bit found;
        int base;
        pressKey(0);
        base = stepCount;
        repeat (2) pulseWheel();
        waitForState(2'd2, 40, found);
        checks++; if (!found) begin errors++; $display("[TB] FAIL reset_enter_wait: got state %0d expected 2", state); end
        repeat (12) tick();
        checks++; if (waitMin !== 8'h01) begin errors++; $display("[TB] FAIL pre_reset_min: got %h expected 01", waitMin); end
        pulseWheel();
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL pre_reset_run: got %0d expected 1", state); end
        checks++; if (stepCount - base !== 0) begin errors++; $display("[TB] FAIL pre_reset_steps: got %0d expected 0", stepCount - base); end
        reset = 1'b0;
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL midreset_state: got %0d expected 0", state); end
        checks++; if (distClrN !== 1'b0) begin errors++; $display("[TB] FAIL midreset_clr_n: got %b expected 0", distClrN); end
        checks++; if (waitMin !== 8'h00) begin errors++; $display("[TB] FAIL midreset_wait_min: got %h expected 00", waitMin); end
        checks++; if (meterOn !== 1'b0) begin errors++; $display("[TB] FAIL midreset_meter_on: got %b expected 0", meterOn); end
        tick();
        reset = 1'b1;
        tick();
        pressKey(0);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL restart_state: got %0d expected 1", state); end
        base = stepCount;
        repeat (3) pulseWheel();
        checks++; if (stepCount - base !== 0) begin errors++; $display("[TB] FAIL restart_three_steps: got %0d expected 0", stepCount - base); end
        pulseWheel();
        checks++; if (stepCount - base !== 1) begin errors++; $display("[TB] FAIL restart_four_steps: got %0d expected 1", stepCount - base); end
    endtask

    initial begin
        test_reset();
        test_distance();
        test_wait_timeout();
        test_minute_saturation();
        test_hold();
        test_mid_trip_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
